// File: rtl/piso_arb_ctrl_if.sv
// Producer/serial-line bundle for piso_arb_ctrl; master drives requests, slave is the serializer.
interface piso_arb_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;
  logic             sout_src;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, sout, sout_valid, sout_first, sout_last, sout_src, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, sout, sout_valid, sout_first, sout_last, sout_src, busy
  );
endinterface

// File: rtl/piso_arb_ctrl.sv
// Round-robin two-producer serializer: first bit one cycle after accept, MSB-first, then GAP_CYCLES idle.
// Backpressure: ready only in IDLE for the granted requester; producers hold valid/data until accepted.
module piso_arb_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  piso_arb_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             pref;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic             sout_q;
  logic             vld_q;
  logic             first_q;
  logic             last_q;
  logic             src_q;

  // pref=1 means requester 1 wins a tie; it flips to the loser on every accept
  always_comb begin
    grant    = bus.req1_valid && (!bus.req0_valid || pref);
    accept   = !rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    acc_data = grant ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      pref    <= 1'b0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            shreg   <= acc_data << 1;
            sout_q  <= acc_data[WIDTH-1];
            vld_q   <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            src_q   <= grant;
            bit_cnt <= '0;
            pref    <= !grant;
          end
        end
        SHIFT: begin
          first_q <= 1'b0;
          // bit_cnt tracks the bit currently on sout
          if (bit_cnt == CW'(WIDTH-1)) begin
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sout_q  <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            last_q  <= (bit_cnt == CW'(WIDTH-2));
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES-1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
  assign bus.sout_first = first_q;
  assign bus.sout_last  = last_q;
  assign bus.sout_src   = src_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Bench for piso_arb_ctrl: a GAP=1 and a GAP=0 instance checked every cycle against a schedule-based model.
module tb_piso_arb_ctrl;
  localparam int W    = 4;
  localparam int RING = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_arb_ctrl_if #(.WIDTH(W)) bus0 ();
  piso_arb_ctrl_if #(.WIDTH(W)) bus1 ();

  piso_arb_ctrl #(.WIDTH(W), .GAP_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  piso_arb_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic         pv [2][2];
  logic [W-1:0] pd [2][2];

  assign bus0.req0_valid = pv[0][0];
  assign bus0.req0_data  = pd[0][0];
  assign bus0.req1_valid = pv[0][1];
  assign bus0.req1_data  = pd[0][1];
  assign bus1.req0_valid = pv[1][0];
  assign bus1.req0_data  = pd[1][0];
  assign bus1.req1_valid = pv[1][1];
  assign bus1.req1_data  = pd[1][1];

  logic [7:0] obs [2];
  assign obs[0] = {bus0.req0_ready, bus0.req1_ready, bus0.sout, bus0.sout_valid,
                   bus0.sout_first, bus0.sout_last, bus0.sout_src, bus0.busy};
  assign obs[1] = {bus1.req0_ready, bus1.req1_ready, bus1.sout, bus1.sout_valid,
                   bus1.sout_first, bus1.sout_last, bus1.sout_src, bus1.busy};

  // producer word queues, one per (instance, requester)
  logic [W-1:0] wbuf [2][2][16];
  int           wh   [2][2];
  int           wt   [2][2];

  // expected per-cycle outputs, scheduled at accept time
  logic s_vld [2][RING];
  logic s_bit [2][RING];
  logic s_fst [2][RING];
  logic s_lst [2][RING];
  logic s_src [2][RING];
  logic s_bsy [2][RING];
  int   idle_from [2];
  logic pref [2];
  logic src_hold [2];
  logic acc_any [2];
  int   last_acc [2];
  int   gap_of [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  logic rnd_mode = 1'b0;

  task automatic push(input int d, input int r, input logic [W-1:0] w);
    wbuf[d][r][wt[d][r] % 16] = w;
    wt[d][r]++;
  endtask

  task automatic clear_ring(input int i);
    for (int s = 0; s < RING; s++) begin
      s_vld[i][s] = 1'b0; s_bit[i][s] = 1'b0; s_fst[i][s] = 1'b0;
      s_lst[i][s] = 1'b0; s_src[i][s] = 1'b0; s_bsy[i][s] = 1'b0;
    end
  endtask

  task automatic cyc();
    int           sl;
    int           s;
    logic         open, r0, r1, g;
    logic [7:0]   exp;
    logic [W-1:0] w;
    logic         acc [2][2];
    @(negedge clk);
    sl = cyc_n % RING;
    for (int i = 0; i < 2; i++) begin
      open = !rst && (cyc_n >= idle_from[i]);
      r0   = open && pv[i][0] && (!pv[i][1] || !pref[i]);
      r1   = open && pv[i][1] && (!pv[i][0] || pref[i]);
      exp  = {r0, r1, s_bit[i][sl], s_vld[i][sl], s_fst[i][sl], s_lst[i][sl],
              s_vld[i][sl] ? s_src[i][sl] : src_hold[i], s_bsy[i][sl]};
      if (cyc_n > 0) begin
        checks++;
        assert (obs[i] === exp) else begin
          errors++;
          $error("FAIL dut%0d cycle %0d {rdy0,rdy1,sout,vld,first,last,src,busy} observed %b expected %b",
                 i, cyc_n, obs[i], exp);
        end
      end
      acc[i][0] = obs[i][7] && pv[i][0];
      acc[i][1] = obs[i][6] && pv[i][1];
      if (s_vld[i][sl]) src_hold[i] = s_src[i][sl];
      s_vld[i][sl] = 1'b0; s_bit[i][sl] = 1'b0; s_fst[i][sl] = 1'b0;
      s_lst[i][sl] = 1'b0; s_src[i][sl] = 1'b0; s_bsy[i][sl] = 1'b0;
      if (rst) begin
        clear_ring(i);
        src_hold[i]  = 1'b0;
        pref[i]      = 1'b0;
        idle_from[i] = cyc_n + 1;
      end else if (r0 || r1) begin
        g = r1;
        w = pd[i][int'(g)];
        for (int k = 1; k <= W; k++) begin
          s = (cyc_n + k) % RING;
          s_vld[i][s] = 1'b1;
          s_bit[i][s] = w[W-k];
          s_fst[i][s] = (k == 1);
          s_lst[i][s] = (k == W);
          s_src[i][s] = g;
        end
        for (int k = 1; k <= W + gap_of[i]; k++) s_bsy[i][(cyc_n + k) % RING] = 1'b1;
        idle_from[i] = cyc_n + W + gap_of[i] + 1;
        pref[i]      = !g;
        acc_any[i]   = 1'b1;
        last_acc[i]  = cyc_n;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (acc[i][r]) pv[i][r] = 1'b0;
        if (rnd_mode && pv[i][r] && $urandom_range(0, 7) == 0) pv[i][r] = 1'b0;
        if (!pv[i][r]) begin
          if (wt[i][r] != wh[i][r]) begin
            pv[i][r] = 1'b1;
            pd[i][r] = wbuf[i][r][wh[i][r] % 16];
            wh[i][r]++;
          end else begin
            pd[i][r] = W'($urandom);
          end
        end
      end
    end
  endtask

  task automatic wait_accept(input int d, input int budget);
    acc_any[d] = 1'b0;
    for (int k = 0; k < budget && !acc_any[d]; k++) cyc();
    checks++;
    assert (acc_any[d] === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout dut%0d observed no accept within %0d cycles, required one", d, budget);
    end
  endtask

  task automatic wait_drain(input int d, input int budget);
    for (int k = 0; k < budget &&
         (pv[d][0] || pv[d][1] || wt[d][0] != wh[d][0] || wt[d][1] != wh[d][1] ||
          cyc_n < idle_from[d]); k++) cyc();
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clear_ring(i);
      idle_from[i] = 0; pref[i] = 1'b0; src_hold[i] = 1'b0; acc_any[i] = 1'b0; last_acc[i] = 0;
      for (int r = 0; r < 2; r++) begin
        pv[i][r] = 1'b0; pd[i][r] = '0; wh[i][r] = 0; wt[i][r] = 0;
      end
    end
    gap_of[0] = 1;
    gap_of[1] = 0;

    // reset held with both requesters valid; contention A vs 5 follows
    pv[0][0] = 1'b1; pd[0][0] = 4'hA;
    pv[0][1] = 1'b1; pd[0][1] = 4'h5;
    pv[1][0] = 1'b1; pd[1][0] = 4'h1;
    push(1, 0, 4'h2); push(1, 0, 4'hE);
    repeat (3) cyc();
    rst = 1'b0;
    wait_accept(0, 3);
    wait_accept(0, 20);

    // req0 reasserted alongside req1: req0 wins because req1 went last
    push(0, 0, 4'b1011);
    push(0, 1, 4'h7);
    wait_drain(0, 60);

    // back-to-back single source on requester 1
    push(0, 1, 4'h3); push(0, 1, 4'hC); push(0, 1, 4'h9);
    wait_accept(0, 20);
    t0 = last_acc[0];
    wait_accept(0, 20);
    checks++;
    assert (last_acc[0] - t0 === 6) else begin
      errors++;
      $error("FAIL b2b_interval observed %0d required 6", last_acc[0] - t0);
    end
    wait_drain(0, 60);

    // GAP=0 instance: continuous req0, accepts 5 cycles apart
    push(1, 0, 4'h5); push(1, 0, 4'hB);
    wait_drain(1, 60);
    push(1, 0, 4'h8); push(1, 0, 4'h4);
    wait_accept(1, 20);
    t0 = last_acc[1];
    wait_accept(1, 20);
    checks++;
    assert (last_acc[1] - t0 === 5) else begin
      errors++;
      $error("FAIL gap0_interval observed %0d required 5", last_acc[1] - t0);
    end
    wait_drain(1, 60);

    // abort: reset during the 2nd bit of F, pending 6 accepted on the first IDLE cycle
    push(0, 0, 4'hF); push(0, 0, 4'h6);
    wait_accept(0, 20);
    t0 = last_acc[0];
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_accept(0, 5);
    checks++;
    assert (last_acc[0] - t0 === 3) else begin
      errors++;
      $error("FAIL abort_reaccept observed %0d required 3", last_acc[0] - t0);
    end
    wait_drain(0, 60);

    // randomized traffic with drops and occasional resets
    rnd_mode = 1'b1;
    repeat (600) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++)
          if (wt[i][r] - wh[i][r] < 4 && $urandom_range(0, 2) == 0) push(i, r, W'($urandom));
      if ($urandom_range(0, 79) == 0) rst = 1'b1;
      cyc();
      rst = 1'b0;
    end
    rnd_mode = 1'b0;
    wait_drain(0, 200);
    wait_drain(1, 200);
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
